// File: rtl/sys_defs_pkg.sv
// Shared system definitions: superscalar width, CDB tag width and the decoded
// instruction packet passed from decode to dispatch.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

package sys_defs;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [`CDB_BITS-1:0] dest_tag;
  } DISPATCH_PACKET;

endpackage

// File: rtl/lead_ones_count.sv
// Counts consecutive ones starting at bit 0; the first zero ends the run.
module lead_ones_count #(
  parameter int N = `N_WAY
) (
  input  logic [N-1:0]       bits_i,
  output logic [$clog2(N):0] count_o
);

  localparam int CW = $clog2(N) + 1;

  always_comb begin : l_count
    logic run;
    count_o = '0;
    run     = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = run & bits_i[i];
      if (run) count_o = count_o + CW'(1);
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular FIFO between decode and dispatch: accepts whole fetch groups when
// there is room and offers the oldest entries limited by ROB and free-list space.
module dispatch_buffer
  import sys_defs::*;
#(
  parameter int DB_DEPTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  DISPATCH_PACKET [`N_WAY-1:0]      fetch_packet,
  input  logic                             squash,
  input  logic [$clog2(`N_WAY):0]          free_num,
  input  logic [$clog2(`N_WAY):0]          empty_rob,
  input  logic [`N_WAY-1:0]                dispatched,
  output DISPATCH_PACKET [`N_WAY-1:0]      dispatch_packet,
  output logic [$clog2(`N_WAY):0]          dispatch_num,
  output logic                             fetch_ready,
  output logic [$clog2(DB_DEPTH):0]        db_count
);

  localparam int NW    = `N_WAY;
  localparam int NUM_W = $clog2(NW) + 1;
  localparam int PTR_W = $clog2(DB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  DISPATCH_PACKET   mem_q [DB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NW-1:0]    fetch_vld;
  logic [NUM_W-1:0] fetch_lead, disp_lead, push_num, pop_num;

  always_comb begin
    for (int i = 0; i < NW; i++) fetch_vld[i] = fetch_packet[i].valid;
  end

  lead_ones_count #(.N(NW)) u_push_cnt (
    .bits_i  (fetch_vld),
    .count_o (fetch_lead)
  );

  lead_ones_count #(.N(NW)) u_pop_cnt (
    .bits_i  (dispatched),
    .count_o (disp_lead)
  );

  // Room for a full group is judged on the registered count only, so a
  // same-cycle pop never opens the door for a push.
  assign fetch_ready = (count_q <= CNT_W'(DB_DEPTH - NW));
  assign db_count    = count_q;

  always_comb begin : l_dnum
    logic [CNT_W-1:0] m;
    m = count_q;
    if (CNT_W'(free_num) < m)  m = CNT_W'(free_num);
    if (CNT_W'(empty_rob) < m) m = CNT_W'(empty_rob);
    if (CNT_W'(NW) < m)        m = CNT_W'(NW);
    dispatch_num = NUM_W'(m);
  end

  always_comb begin
    pop_num  = (disp_lead < dispatch_num) ? disp_lead : dispatch_num;
    push_num = fetch_ready ? fetch_lead : '0;
    head_d   = head_q + PTR_W'(pop_num);
    tail_d   = tail_q + PTR_W'(push_num);
    count_d  = count_q + CNT_W'(push_num) - CNT_W'(pop_num);
  end

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      dispatch_packet[i]       = mem_q[head_q + PTR_W'(i)];
      dispatch_packet[i].valid = (NUM_W'(i) < dispatch_num);
    end
  end

  // Payload storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < NW; i++) begin
        if (NUM_W'(i) < push_num) mem_q[tail_q + PTR_W'(i)] <= fetch_packet[i];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer (N_WAY=2, DB_DEPTH=8): directed table, corner
// sequences and random traffic, all checked against a queue-based model.
module tb_dispatch_buffer;
  import sys_defs::*;

  localparam int NW = 2;
  localparam int D  = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  DISPATCH_PACKET [1:0]  fetch_packet;
  logic                  squash;
  logic [1:0]            free_num, empty_rob, dispatched;
  DISPATCH_PACKET [1:0]  dispatch_packet;
  logic [1:0]            dispatch_num;
  logic                  fetch_ready;
  logic [3:0]            db_count;

  int vectors     = 0;
  int miscompares = 0;

  DISPATCH_PACKET model_q [$];

  typedef struct {
    logic       rst;
    logic       sq;
    logic [1:0] fv;
    logic [1:0] fn;
    logic [1:0] er;
    logic [1:0] disp;
    bit         chk;
    int         exp_num;
    int         exp_ready;
    int         exp_cnt;
  } row_t;

  row_t tbl [20];

  dispatch_buffer #(.DB_DEPTH(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_packet    (fetch_packet),
    .squash          (squash),
    .free_num        (free_num),
    .empty_rob       (empty_rob),
    .dispatched      (dispatched),
    .dispatch_packet (dispatch_packet),
    .dispatch_num    (dispatch_num),
    .fetch_ready     (fetch_ready),
    .db_count        (db_count)
  );

  always #5 clock = ~clock;

  function automatic row_t mk(logic rst, logic sq, logic [1:0] fv, logic [1:0] fn,
                              logic [1:0] er, logic [1:0] disp,
                              int en, int erdy, int ec);
    row_t r;
    r.rst = rst; r.sq = sq; r.fv = fv; r.fn = fn; r.er = er; r.disp = disp;
    r.chk = 1'b1; r.exp_num = en; r.exp_ready = erdy; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lead_ones(logic [1:0] b);
    if (b[0] == 1'b0) return 0;
    if (b[1] == 1'b0) return 1;
    return 2;
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic apply(row_t r);
    int cnt, m, pops, pushes;
    bit rdy;
    DISPATCH_PACKET e;
    @(negedge clock);
    reset     = r.rst;
    squash    = r.sq;
    free_num  = r.fn;
    empty_rob = r.er;
    dispatched = r.disp;
    for (int i = 0; i < NW; i++) begin
      fetch_packet[i].valid    = r.fv[i];
      fetch_packet[i].pc       = $urandom;
      fetch_packet[i].inst     = $urandom;
      fetch_packet[i].dest_tag = 6'($urandom);
    end
    #1;
    cnt = model_q.size();
    m   = min2(min2(cnt, int'(r.fn)), min2(int'(r.er), NW));
    rdy = (D - cnt) >= NW;
    check("dispatch_num", 128'(dispatch_num), 128'(m));
    check("fetch_ready", 128'(fetch_ready), 128'(rdy));
    check("db_count", 128'(db_count), 128'(cnt));
    for (int i = 0; i < NW; i++) begin
      if (i < m) check($sformatf("lane%0d_packet", i), 128'(dispatch_packet[i]), 128'(model_q[i]));
      else       check($sformatf("lane%0d_valid", i), 128'(dispatch_packet[i].valid), 128'(0));
    end
    if (r.chk) begin
      check("tbl_dispatch_num", 128'(dispatch_num), 128'(r.exp_num));
      check("tbl_fetch_ready", 128'(fetch_ready), 128'(r.exp_ready));
      check("tbl_db_count", 128'(db_count), 128'(r.exp_cnt));
    end
    if (r.rst || r.sq) begin
      model_q.delete();
    end else begin
      pops = min2(lead_ones(r.disp), m);
      for (int k = 0; k < pops; k++) void'(model_q.pop_front());
      pushes = rdy ? lead_ones(r.fv) : 0;
      for (int k = 0; k < pushes; k++) begin
        e = fetch_packet[k];
        e.valid = 1'b1;
        model_q.push_back(e);
      end
    end
  endtask

  initial begin
    row_t r;
    reset = 1'b1; squash = 1'b0; free_num = 2'd2; empty_rob = 2'd2; dispatched = 2'b00;
    fetch_packet = '0;
    repeat (2) @(posedge clock);
    model_q.delete();

    //          rst sq  fv     fn    er    disp   num rdy cnt
    tbl[0]  = mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 0, 1, 0);
    tbl[1]  = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b00, 2, 1, 2);
    tbl[2]  = mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 2);
    tbl[3]  = mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 4);
    tbl[4]  = mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 6);
    tbl[5]  = mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 0, 8);
    tbl[6]  = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b00, 2, 0, 8);
    tbl[7]  = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b11, 2, 0, 8);
    tbl[8]  = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b10, 2, 1, 6);
    tbl[9]  = mk(0, 0, 2'b00, 2'd0, 2'd2, 2'b11, 0, 1, 6);
    tbl[10] = mk(0, 0, 2'b00, 2'd2, 2'd0, 2'b11, 0, 1, 6);
    tbl[11] = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b11, 2, 1, 6);
    tbl[12] = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b01, 2, 1, 4);
    tbl[13] = mk(0, 0, 2'b00, 2'd1, 2'd2, 2'b01, 1, 1, 3);
    tbl[14] = mk(0, 0, 2'b00, 2'd1, 2'd2, 2'b11, 1, 1, 2);
    tbl[15] = mk(0, 0, 2'b01, 2'd2, 2'd2, 2'b01, 1, 1, 1);
    tbl[16] = mk(0, 0, 2'b10, 2'd2, 2'd2, 2'b00, 1, 1, 1);
    tbl[17] = mk(0, 0, 2'b11, 2'd2, 2'd1, 2'b00, 1, 1, 1);
    tbl[18] = mk(0, 1, 2'b11, 2'd2, 2'd2, 2'b11, 2, 1, 3);
    tbl[19] = mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b00, 0, 1, 0);
    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Walk head to index 7, then straddle the wrap with two entries.
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 0, 1, 0));
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 2));
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 4));
    apply(mk(0, 0, 2'b01, 2'd2, 2'd2, 2'b00, 2, 1, 6));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b11, 2, 0, 7));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b11, 2, 1, 5));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b11, 2, 1, 3));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b01, 1, 1, 1));
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 0, 1, 0));
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b11, 2, 1, 2));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b00, 2, 1, 2));

    // Squash at count 5 with a valid push in the same cycle.
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 2));
    apply(mk(0, 0, 2'b01, 2'd2, 2'd2, 2'b00, 2, 1, 4));
    apply(mk(0, 1, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 5));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b00, 0, 1, 0));

    // Reset mid-stream overriding push and pop.
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 0, 1, 0));
    apply(mk(0, 0, 2'b11, 2'd2, 2'd2, 2'b00, 2, 1, 2));
    apply(mk(1, 1, 2'b11, 2'd2, 2'd2, 2'b11, 2, 1, 4));
    apply(mk(0, 0, 2'b00, 2'd2, 2'd2, 2'b00, 0, 1, 0));

    for (int n = 0; n < 400; n++) begin
      r.rst  = ($urandom_range(0, 63) == 0);
      r.sq   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       r.fv = 2'b00;
        1:       r.fv = 2'b01;
        default: r.fv = 2'b11;
      endcase
      r.fn   = 2'($urandom_range(0, 2));
      r.er   = 2'($urandom_range(0, 2));
      r.disp = 2'($urandom);
      r.chk  = 1'b0;
      r.exp_num = 0; r.exp_ready = 0; r.exp_cnt = 0;
      apply(r);
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter `N_WAY`, default 2: superscalar width, shared macro.
REQ-002 Parameter DB_DEPTH, default 8: buffer entries; power of two and at least 2*`N_WAY`.
REQ-003 clock  input  1  single clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_packet  input  DISPATCH_PACKET[`N_WAY]  decoded instructions from fetch/decode; valid lanes contiguous from lane 0.
REQ-006 squash  input  1  flush the whole buffer (branch mispredict).
REQ-007 free_num  input  clog2(`N_WAY)+1  free physical registers available, from free list.
REQ-008 empty_rob  input  clog2(`N_WAY)+1  free ROB slots, from ROB.
REQ-009 dispatched  input  [`N_WAY]  per-lane acceptance from ROB/free list, same cycle.
REQ-010 dispatch_packet  output  DISPATCH_PACKET[`N_WAY]  oldest instructions, lane 0 oldest.
REQ-011 dispatch_num  output  clog2(`N_WAY)+1  lanes offered this cycle.
REQ-012 fetch_ready  output  1  buffer accepts a full fetch group this cycle.
REQ-013 db_count  output  clog2(DB_DEPTH)+1  occupied entries (debug).

Function
REQ-014 Storage: circular FIFO with head, tail and count registers; head and tail wrap modulo DB_DEPTH.
REQ-015 dispatch_num: min(db_count, free_num, empty_rob, `N_WAY`), computed combinationally from registered state and inputs.
REQ-016 dispatch_packet[i]: entry (head+i) mod DB_DEPTH; its .valid is 1 iff i < dispatch_num; other fields are don't-care when invalid.
REQ-017 Pop count: number of leading ones of dispatched, lane 0 upward, clipped to dispatch_num; a 1 above a 0 is ignored.
REQ-018 fetch_ready: 1 iff (DB_DEPTH - db_count) >= `N_WAY`, from registered count only, with no dependence on the same-cycle pop.
REQ-019 Push: when fetch_ready=1, leading valid lanes of fetch_packet are written at tail in lane order, and the push count equals the number of those lanes.
REQ-020 When fetch_ready=0, fetch_packet is ignored and nothing is written.
REQ-021 Simultaneous push and pop in one cycle: next count = count + push - pop; entries being popped are never overwritten in that cycle.
REQ-022 Latency: an instruction pushed in cycle N can appear on dispatch_packet no earlier than cycle N+1; there is no bypass.
REQ-023 squash: head=tail=count=0 at the next edge; same-cycle push and pop are discarded; squash has priority over all other updates.
REQ-024 Empty (count=0): dispatch_num=0 and every dispatch_packet .valid=0.
REQ-025 Full (count=DB_DEPTH): fetch_ready=0, and pop still proceeds.
REQ-026 Either free_num=0 or empty_rob=0 forces dispatch_num=0, and contents are held.

Reset
REQ-027 On reset at a clock edge: head=tail=count=0, so outputs become dispatch_num=0, all .valid=0, fetch_ready=1 and db_count=0.
REQ-028 Reset overrides squash, push and pop, and reset asserted mid-stream discards all contents.
REQ-029 Entry payload storage is not reset.

Structure
REQ-030 DISPATCH_PACKET, `N_WAY` and `CDB_BITS` come from the shared sys_defs package, and this block adds no new typedef.
REQ-031 One sub-module, lead_ones_count (`N_WAY`-bit leading-ones counter), is used for the pop and push counts.
REQ-032 Body: a single always_ff for pointers, count and storage, plus always_comb for the output select.

Verification (N_WAY=2, DB_DEPTH=8)
REQ-033 Reset, then push A,B with dispatched=2'b00 -> next cycle dispatch_num=2, lanes A,B valid, db_count=2.
REQ-034 Fill to 8 entries with no dispatch -> fetch_ready=0; next fetch group dropped; db_count stays 8.
REQ-035 count=3, free_num=1, empty_rob=2 -> dispatch_num=1; dispatched=2'b01 -> db_count=2, head advances by 1.
REQ-036 dispatched=2'b10 with dispatch_num=2 -> pop=0 and contents held.
REQ-037 Wrap: with head=7 and count=2, entries at indices 7 and 0 appear on lanes 0 and 1; simultaneous push 2 and pop 2 -> count stays 2, with no corruption.
REQ-038 squash with count=5 and a valid push -> next cycle db_count=0, dispatch_num=0, fetch_ready=1.
